// File: rtl/icache_tag_ctrl.sv
// Instruction-cache tag controller: looks up fetch tags in an external tag FIFO,
// drives line refills on a miss, installs the new tag and serves cache flushes.
module icache_tag_ctrl #(
  parameter int DP    = 4,
  parameter int TAG_W = 7,
  parameter int BEATS = 4,
  localparam int AW   = $clog2(DP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush_req,
  input  logic             cpu_req,
  input  logic [TAG_W-1:0] cpu_tag,
  output logic             cpu_ack,
  output logic             cpu_err,
  output logic [AW-1:0]    cpu_hindex,
  output logic [TAG_W-1:0] tag_cmp_data,
  input  logic [DP-1:0]    tag_hit,
  input  logic [AW-1:0]    tag_wptr,
  output logic             tag_wr,
  output logic [TAG_W:0]   tag_wdata,
  output logic             flush,
  output logic             mem_req,
  output logic [TAG_W-1:0] mem_tag,
  output logic [AW-1:0]    mem_slot,
  input  logic             mem_ack,
  input  logic             mem_rvalid,
  input  logic             mem_rlast,
  output logic             busy,
  output logic [15:0]      hit_cnt,
  output logic [15:0]      miss_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_REQ, S_DATA, S_TWR, S_FLUSH
  } state_t;

  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  state_t             state_q, state_d;
  logic [TAG_W-1:0]   tag_q;
  logic [AW-1:0]      slot_q;
  logic [3:0]         beat_q;
  logic               pend_q;
  logic               relook_q;
  logic               flush_pend;
  logic               accept;
  logic               hit_any;
  logic               beat_end;
  logic               beat_good;

  function automatic logic [AW-1:0] hi_idx(input logic [DP-1:0] v);
    hi_idx = '0;
    for (int i = 0; i < DP; i++)
      if (v[i]) hi_idx = AW'(i);
  endfunction

  assign flush_pend = flush_req | pend_q;
  // A requester holds cpu_req until it sees the response; don't re-accept in that cycle.
  assign accept     = cpu_req & ~cpu_ack & ~cpu_err & ~flush_pend;
  assign hit_any    = |tag_hit;
  assign beat_end   = mem_rvalid & (mem_rlast | (beat_q == LAST_BEAT));
  assign beat_good  = mem_rvalid & mem_rlast & (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (flush_pend) state_d = S_FLUSH;
                else if (accept) state_d = S_LOOKUP;
      S_LOOKUP: state_d = hit_any ? S_IDLE : S_REQ;
      S_REQ:    if (mem_ack) state_d = S_DATA;
      S_DATA:   if (beat_end) state_d = beat_good ? S_TWR : S_IDLE;
      S_TWR:    state_d = S_LOOKUP;
      S_FLUSH:  state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tag_q      <= '0;
      slot_q     <= '0;
      beat_q     <= '0;
      pend_q     <= 1'b0;
      relook_q   <= 1'b0;
      cpu_ack    <= 1'b0;
      cpu_err    <= 1'b0;
      cpu_hindex <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      state_q <= state_d;
      cpu_ack <= 1'b0;
      cpu_err <= 1'b0;
      case (state_q)
        S_IDLE: if (state_d == S_LOOKUP) begin
          tag_q    <= cpu_tag;
          relook_q <= 1'b0;
        end
        S_LOOKUP: if (hit_any) begin
          cpu_ack    <= 1'b1;
          cpu_hindex <= hi_idx(tag_hit);
          relook_q   <= 1'b0;
          if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
        end else begin
          slot_q <= tag_wptr;
          // The lookup following a tag install is not a fresh miss.
          if (!relook_q && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
        end
        S_REQ:  if (mem_ack) beat_q <= '0;
        S_DATA: if (mem_rvalid) begin
          beat_q <= beat_q + 4'd1;
          if (beat_end && !beat_good) cpu_err <= 1'b1;
        end
        S_TWR:  relook_q <= 1'b1;
        default: ;
      endcase
      if (state_q == S_FLUSH) pend_q <= 1'b0;
      else if (flush_req && state_q != S_IDLE) pend_q <= 1'b1;
    end
  end

  assign tag_cmp_data = tag_q;
  assign tag_wdata    = {1'b1, tag_q};
  assign tag_wr       = (state_q == S_TWR);
  assign flush        = (state_q == S_FLUSH);
  assign mem_req      = (state_q == S_REQ);
  assign mem_tag      = tag_q;
  assign mem_slot     = slot_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Bench for icache_tag_ctrl: directed scenarios plus random fetches against a
// behavioural tag-store model and transaction-level expectations.
module tb_icache_tag_ctrl;
  localparam int DP    = 4;
  localparam int TAG_W = 7;
  localparam int BEATS = 4;
  localparam int AW    = $clog2(DP);

  logic             clk = 1'b0;
  logic             reset, flush_req, cpu_req, mem_ack, mem_rvalid, mem_rlast;
  logic [TAG_W-1:0] cpu_tag;
  logic             cpu_ack, cpu_err, tag_wr, flush, mem_req, busy;
  logic [AW-1:0]    cpu_hindex, tag_wptr, mem_slot;
  logic [TAG_W-1:0] tag_cmp_data, mem_tag;
  logic [TAG_W:0]   tag_wdata;
  logic [DP-1:0]    tag_hit, hit_drv, fifo_hit;
  logic [AW-1:0]    wptr_drv;
  logic [15:0]      hit_cnt, miss_cnt;
  logic             use_fifo, env_clr;

  // tag-store model
  logic [TAG_W-1:0] env_tag [DP];
  logic             env_val [DP];
  logic [AW-1:0]    env_wptr;

  int n_cmp = 0, n_bad = 0;
  int n_tagwr = 0, n_ack = 0;
  int exp_hit = 0, exp_miss = 0;

  always #5 clk = ~clk;

  icache_tag_ctrl #(.DP(DP), .TAG_W(TAG_W), .BEATS(BEATS)) dut (
    .clk(clk), .reset(reset), .flush_req(flush_req), .cpu_req(cpu_req), .cpu_tag(cpu_tag),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_hindex(cpu_hindex), .tag_cmp_data(tag_cmp_data),
    .tag_hit(tag_hit), .tag_wptr(tag_wptr), .tag_wr(tag_wr), .tag_wdata(tag_wdata), .flush(flush),
    .mem_req(mem_req), .mem_tag(mem_tag), .mem_slot(mem_slot), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rlast(mem_rlast), .busy(busy), .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  always @(posedge clk) begin
    if (env_clr || flush) begin
      for (int i = 0; i < DP; i++) env_val[i] <= 1'b0;
      if (env_clr) env_wptr <= '0;
    end else if (tag_wr) begin
      env_val[env_wptr] <= 1'b1;
      env_tag[env_wptr] <= tag_wdata[TAG_W-1:0];
      env_wptr          <= env_wptr + 1'b1;
    end
  end

  always_comb begin
    fifo_hit = '0;
    for (int i = 0; i < DP; i++)
      if (env_val[i] && env_tag[i] == tag_cmp_data) fifo_hit[i] = 1'b1;
  end

  assign tag_hit  = use_fifo ? fifo_hit : hit_drv;
  assign tag_wptr = use_fifo ? env_wptr : wptr_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cpu_ack) n_ack++;
    if (tag_wr) n_tagwr++;
    if (!reset) chk("onehot", 32'($countones({cpu_ack, cpu_err, tag_wr, flush}) <= 1), 32'd1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int sat(input int v);
    return (v < 65535) ? v + 1 : 65535;
  endfunction

  task automatic do_reset();
    reset = 1'b1; env_clr = 1'b1;
    cpu_req = 1'b0; flush_req = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0;
    tick(); tick();
    reset = 1'b0; env_clr = 1'b0;
    exp_hit = 0; exp_miss = 0;
  endtask

  // Reference lookup: what the tag store would report for tag t.
  task automatic model_lookup(input logic [TAG_W-1:0] t, output bit hit, output int idx);
    hit = 0; idx = 0;
    for (int i = 0; i < DP; i++) begin
      if (use_fifo ? (env_val[i] && env_tag[i] == t) : hit_drv[i]) begin
        hit = 1; idx = i;
      end
    end
  endtask

  // mode 0: good refill, 1: rlast on beat `early`, 2: BEATS beats with no rlast
  task automatic run_txn(input logic [TAG_W-1:0] t, input int mode, input int early,
                         input int ack_dly, input bit inj_flush);
    bit hit; int idx, slot, nb, wr0;
    model_lookup(t, hit, idx);
    slot = use_fifo ? int'(env_wptr) : int'(wptr_drv);
    wr0 = n_tagwr;
    cpu_tag = t; cpu_req = 1'b1;
    tick();
    chk("lookup_busy", busy, 1);
    chk("cmp_data", tag_cmp_data, t);
    tick();
    if (hit) begin
      chk("hit_ack", cpu_ack, 1);
      chk("hit_index", cpu_hindex, idx);
      exp_hit = sat(exp_hit);
      cpu_req = 1'b0;
    end else begin
      exp_miss = sat(exp_miss);
      chk("mem_req", mem_req, 1);
      chk("mem_tag", mem_tag, t);
      chk("mem_slot", mem_slot, slot);
      repeat (ack_dly) tick();
      chk("mem_req_hold", {mem_req, mem_slot}, {1'b1, AW'(slot)});
      mem_ack = 1'b1; tick(); mem_ack = 1'b0;
      chk("mem_req_drop", mem_req, 0);
      nb = (mode == 1) ? early : BEATS;
      for (int b = 1; b <= nb; b++) begin
        if ($urandom_range(0, 1) == 1) tick();
        mem_rvalid = 1'b1;
        mem_rlast  = (mode != 2) && (b == nb);
        flush_req  = inj_flush && (b == 1);
        tick();
        mem_rvalid = 1'b0; mem_rlast = 1'b0; flush_req = 1'b0;
      end
      if (mode == 0) begin
        chk("tag_wr", tag_wr, 1);
        chk("tag_wdata", tag_wdata, {1'b1, t});
        if (!use_fifo) hit_drv = DP'(1) << slot;
        tick();
        chk("tag_wr_once", tag_wr, 0);
        tick();
        chk("refill_ack", cpu_ack, 1);
        chk("refill_index", cpu_hindex, slot);
        exp_hit = sat(exp_hit);
      end else begin
        chk("refill_err", cpu_err, 1);
        chk("err_idle", busy, 0);
      end
      cpu_req = 1'b0;
      chk("tag_wr_count", n_tagwr - wr0, (mode == 0) ? 1 : 0);
    end
    tick();
    if (inj_flush) begin
      chk("pend_flush", flush, 1);
      tick();
      chk("pend_flush_once", flush, 0);
    end
    chk("idle_after", busy, 0);
    chk("hit_cnt", hit_cnt, exp_hit);
    chk("miss_cnt", miss_cnt, exp_miss);
  endtask

  initial begin
    int a0, w0;
    use_fifo = 1'b0; hit_drv = '0; wptr_drv = '0; cpu_tag = '0;
    do_reset();
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {cpu_ack, cpu_err, tag_wr, flush, mem_req}, 0);
    chk("rst_cnt", {hit_cnt, miss_cnt}, 0);
    chk("rst_tag", tag_cmp_data, 0);

    // hit, highest-set-bit index
    hit_drv = 4'b0100;
    run_txn(7'h15, 0, 0, 0, 0);
    hit_drv = 4'b1010;
    run_txn(7'h2A, 0, 0, 0, 0);

    // miss and full refill from a clean start
    do_reset();
    hit_drv = '0; wptr_drv = 2'd3;
    run_txn(7'h15, 0, 0, 1, 0);

    // early rlast on beat 2, then a refill missing rlast
    hit_drv = '0; wptr_drv = 2'd1;
    run_txn(7'h33, 1, 2, 0, 0);
    hit_drv = '0; wptr_drv = 2'd0;
    run_txn(7'h0F, 2, 0, 2, 0);

    // flush during DATA is deferred until the refill finishes
    hit_drv = '0; wptr_drv = 2'd2;
    run_txn(7'h44, 0, 0, 0, 1);

    // flush together with a fetch in IDLE: flush wins
    hit_drv = 4'b0001;
    flush_req = 1'b1; cpu_req = 1'b1; cpu_tag = 7'h11;
    tick();
    flush_req = 1'b0;
    chk("flush_first", {flush, busy}, 2'b11);
    tick();
    chk("flush_done", {flush, busy}, 2'b00);
    tick();
    chk("req_after_flush", busy, 1);
    tick();
    chk("ack_after_flush", cpu_ack, 1);
    exp_hit = sat(exp_hit);
    cpu_req = 1'b0;
    tick();
    chk("hit_cnt_after_flush", hit_cnt, exp_hit);

    // reset in the middle of a refill
    hit_drv = '0; wptr_drv = 2'd1;
    cpu_tag = 7'h5A; cpu_req = 1'b1;
    tick(); tick();
    mem_ack = 1'b1; tick(); mem_ack = 1'b0;
    repeat (2) begin mem_rvalid = 1'b1; tick(); end
    mem_rvalid = 1'b0; cpu_req = 1'b0; reset = 1'b1;
    a0 = n_ack; w0 = n_tagwr;
    tick();
    reset = 1'b0; exp_hit = 0; exp_miss = 0;
    chk("midrst_busy", busy, 0);
    chk("midrst_memreq", mem_req, 0);
    chk("midrst_cnt", {hit_cnt, miss_cnt}, 0);
    chk("midrst_tag", tag_cmp_data, 0);
    repeat (6) tick();
    chk("midrst_no_wr", n_tagwr - w0, 0);
    chk("midrst_no_ack", n_ack - a0, 0);

    // hit counter saturation
    force dut.hit_cnt = 16'hFFFE;
    tick();
    release dut.hit_cnt;
    exp_hit = 65534;
    hit_drv = 4'b0010;
    run_txn(7'h01, 0, 0, 0, 0);
    run_txn(7'h02, 0, 0, 0, 0);

    // random fetches against the tag-store model
    do_reset();
    use_fifo = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) begin
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        chk("rnd_flush", flush, 1);
        tick();
      end
      run_txn(TAG_W'($urandom_range(0, 5)), (r < 7) ? 0 : (r < 9) ? 1 : 2,
              $urandom_range(1, BEATS - 1), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
